// File: rtl/jt12_lfo_dec_pkg.sv
// rtl/jt12_lfo_dec_pkg.sv - shared widths, PMS depth table, AMS encodings and decode helpers
package jt12_lfo_dec_pkg;

   localparam int JT12_FNUM_W  = 11;
   localparam int JT12_AM_W    = 9;
   localparam int JT12_LFO_W   = 7;
   localparam int JT12_PROD_W  = 10;
   localparam int JT12_DEPTH_W = 5;
   localparam int JT12_DELTA_W = 9;

   // PM depth multiplier indexed by pms
   localparam logic [JT12_DEPTH_W-1:0] PMS_DEPTH [8] =
      '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd8, 5'd16};

   typedef enum logic [1:0] {
      AMS_OFF  = 2'd0,
      AMS_SHR3 = 2'd1,
      AMS_SHL1 = 2'd2,
      AMS_SHL2 = 2'd3
   } ams_e;

   function automatic logic [2:0] pm_step(input logic [4:0] pm_idx);
      return pm_idx[3] ? ~pm_idx[2:0] : pm_idx[2:0];
   endfunction

   function automatic logic [JT12_AM_W-1:0] am_scale(input logic [5:0] am6, input logic [1:0] ams);
      logic [JT12_AM_W-1:0] wide;
      logic [JT12_AM_W-1:0] res;
      wide = {3'b000, am6};
      case (ams_e'(ams))
         AMS_SHR3: res = wide >> 3;
         AMS_SHL1: res = wide << 1;
         AMS_SHL2: res = wide << 2;
         default:  res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/jt12_lfo_dec_if.sv
// rtl/jt12_lfo_dec_if.sv - slot stream and LFO control bundle for the LFO decoder
interface jt12_lfo_dec_if;
   import jt12_lfo_dec_pkg::*;

   logic                   zero;
   logic                   lfo_en;
   logic [JT12_LFO_W-1:0]  lfo_mod;
   logic                   in_valid;
   logic [JT12_FNUM_W-1:0] fnum;
   logic [2:0]             pms;
   logic [1:0]             ams;
   logic                   out_valid;
   logic [JT12_FNUM_W-1:0] fnum_mod;
   logic [JT12_AM_W-1:0]   am_att;

   modport master (
      output zero, lfo_en, lfo_mod, in_valid, fnum, pms, ams,
      input  out_valid, fnum_mod, am_att
   );

   modport slave (
      input  zero, lfo_en, lfo_mod, in_valid, fnum, pms, ams,
      output out_valid, fnum_mod, am_att
   );

endinterface

// File: rtl/jt12_lfo_pm_mul.sv
// rtl/jt12_lfo_pm_mul.sv - PM stages S2/S3: fnum x step product, depth scaling, add/sub and clamp
module jt12_lfo_pm_mul
   import jt12_lfo_dec_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic                    en,
   input  logic                    sign,
   input  logic [2:0]              step,
   input  logic [JT12_DEPTH_W-1:0] depth,
   input  logic [JT12_FNUM_W-1:0]  fnum,
   output logic                    s2_valid,
   output logic                    out_valid,
   output logic [JT12_FNUM_W-1:0]  fnum_mod
);

   localparam int SCALED_W = 14;

   logic                    s2_valid_q, s2_valid_d;
   logic                    s2_en_q, s2_en_d;
   logic                    s2_sign_q, s2_sign_d;
   logic [JT12_DEPTH_W-1:0] s2_depth_q, s2_depth_d;
   logic [JT12_FNUM_W-1:0]  s2_fnum_q, s2_fnum_d;
   logic [JT12_PROD_W-1:0]  s2_prod_q, s2_prod_d;
   logic                    out_valid_q, out_valid_d;
   logic [JT12_FNUM_W-1:0]  fnum_mod_q, fnum_mod_d;

   logic [SCALED_W-1:0]     scaled;
   logic [JT12_DELTA_W-1:0] delta;
   logic [4:0]              unused_frac;
   logic signed [12:0]      wide_fnum;
   logic signed [12:0]      wide_delta;
   logic signed [12:0]      res;
   logic [JT12_FNUM_W-1:0]  clamped;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q  <= 1'b0;
         s2_en_q     <= 1'b0;
         s2_sign_q   <= 1'b0;
         s2_depth_q  <= '0;
         s2_fnum_q   <= '0;
         s2_prod_q   <= '0;
         out_valid_q <= 1'b0;
         fnum_mod_q  <= '0;
      end else begin
         s2_valid_q  <= s2_valid_d;
         s2_en_q     <= s2_en_d;
         s2_sign_q   <= s2_sign_d;
         s2_depth_q  <= s2_depth_d;
         s2_fnum_q   <= s2_fnum_d;
         s2_prod_q   <= s2_prod_d;
         out_valid_q <= out_valid_d;
         fnum_mod_q  <= fnum_mod_d;
      end
   end

   always_comb begin
      s2_valid_d = in_valid;
      s2_en_d    = en;
      s2_sign_d  = sign;
      s2_depth_d = depth;
      s2_fnum_d  = fnum;
      // Largest product is 127 x 7 = 889, fits the 10-bit register
      s2_prod_d  = {3'b000, fnum[10:4]} * {7'b0000000, step};
   end

   always_comb begin
      // 889 x 16 = 14224 fits in 14 bits; the low 5 bits are the discarded fraction
      scaled               = {4'b0000, s2_prod_q} * {9'b000000000, s2_depth_q};
      {delta, unused_frac} = scaled;
      if (!s2_en_q) begin
         delta = '0;
      end
      wide_fnum  = $signed({2'b00, s2_fnum_q});
      wide_delta = $signed({4'b0000, delta});
      res        = s2_sign_q ? (wide_fnum - wide_delta) : (wide_fnum + wide_delta);
      if (res < 13'sd0) begin
         clamped = '0;
      end else if (res > 13'sd2047) begin
         clamped = '1;
      end else begin
         clamped = res[10:0];
      end
      out_valid_d = s2_valid_q;
      fnum_mod_d  = s2_valid_q ? clamped : '0;
   end

   assign s2_valid  = s2_valid_q;
   assign out_valid = out_valid_q;
   assign fnum_mod  = fnum_mod_q;

endmodule

// File: rtl/jt12_lfo_dec.sv
// rtl/jt12_lfo_dec.sv - LFO modulation decoder: sweep latch, S1 decode, inline AM path, PM sub-pipeline
module jt12_lfo_dec
   import jt12_lfo_dec_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   jt12_lfo_dec_if.slave bus
);

   logic [JT12_LFO_W-1:0]   lfo_lat_q, lfo_lat_d;
   logic                    s1_valid_q, s1_valid_d;
   logic                    s1_en_q, s1_en_d;
   logic [JT12_FNUM_W-1:0]  s1_fnum_q, s1_fnum_d;
   logic                    s1_sign_q, s1_sign_d;
   logic [2:0]              s1_step_q, s1_step_d;
   logic [JT12_DEPTH_W-1:0] s1_depth_q, s1_depth_d;
   logic [JT12_AM_W-1:0]    s1_am_q, s1_am_d;
   logic [JT12_AM_W-1:0]    s2_am_q, s2_am_d;
   logic [JT12_AM_W-1:0]    am_att_q, am_att_d;

   logic [4:0]              pm_idx;
   logic [5:0]              am6;
   logic                    s2_valid;
   logic                    pm_out_valid;
   logic [JT12_FNUM_W-1:0]  pm_fnum_mod;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfo_lat_q  <= '0;
         s1_valid_q <= 1'b0;
         s1_en_q    <= 1'b0;
         s1_fnum_q  <= '0;
         s1_sign_q  <= 1'b0;
         s1_step_q  <= '0;
         s1_depth_q <= '0;
         s1_am_q    <= '0;
         s2_am_q    <= '0;
         am_att_q   <= '0;
      end else begin
         lfo_lat_q  <= lfo_lat_d;
         s1_valid_q <= s1_valid_d;
         s1_en_q    <= s1_en_d;
         s1_fnum_q  <= s1_fnum_d;
         s1_sign_q  <= s1_sign_d;
         s1_step_q  <= s1_step_d;
         s1_depth_q <= s1_depth_d;
         s1_am_q    <= s1_am_d;
         s2_am_q    <= s2_am_d;
         am_att_q   <= am_att_d;
      end
   end

   // Slots decode from the registered latch, so a slot coincident with zero sees the old value
   always_comb begin
      lfo_lat_d = lfo_lat_q;
      if (!bus.lfo_en) begin
         lfo_lat_d = '0;
      end else if (bus.zero) begin
         lfo_lat_d = bus.lfo_mod;
      end
      pm_idx = lfo_lat_q[6:2];
      am6    = lfo_lat_q[6] ? lfo_lat_q[5:0] : ~lfo_lat_q[5:0];
   end

   always_comb begin
      s1_valid_d = bus.in_valid;
      s1_en_d    = bus.lfo_en;
      s1_fnum_d  = bus.fnum;
      s1_sign_d  = pm_idx[4];
      s1_step_d  = pm_step(pm_idx);
      s1_depth_d = PMS_DEPTH[bus.pms];
      s1_am_d    = am_scale(am6, bus.ams);
   end

   always_comb begin
      s2_am_d  = s1_en_q ? s1_am_q : '0;
      am_att_d = s2_valid ? s2_am_q : '0;
   end

   jt12_lfo_pm_mul u_pm_mul (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s1_valid_q),
      .en        (s1_en_q),
      .sign      (s1_sign_q),
      .step      (s1_step_q),
      .depth     (s1_depth_q),
      .fnum      (s1_fnum_q),
      .s2_valid  (s2_valid),
      .out_valid (pm_out_valid),
      .fnum_mod  (pm_fnum_mod)
   );

   assign bus.out_valid = pm_out_valid;
   assign bus.fnum_mod  = pm_fnum_mod;
   assign bus.am_att    = am_att_q;

endmodule
